// File: rtl/capacity_arbiter_pkg.sv
// capacity_pkg: shared widths, FSM/requester enums and slot-position helpers
// for the product-capacity arbiter and its register file.
// Optional build macro used elsewhere in this slice: SOLDOUT_MAP_EN.
package capacity_pkg;

  localparam int LINE_W        = 3;
  localparam int COL_W         = 4;
  localparam int CAP_W         = 5;
  localparam int SLOT_IDX_W    = 6;
  localparam int NUM_LINES_DEF = 6;
  localparam int NUM_COLS_DEF  = 8;

  typedef enum logic [1:0] {IDLE, CHECK, COMMIT, RELEASE} state_e;
  typedef enum logic {REQ_ADM, REQ_CUS} req_id_e;

  // Line 1 is a half-width line: only the odd columns 1,3,5,7 exist.
  function automatic logic slot_valid(input logic [LINE_W-1:0] line,
                                      input logic [COL_W-1:0]  col,
                                      input int num_lines = NUM_LINES_DEF,
                                      input int num_cols  = NUM_COLS_DEF);
    int l;
    int c;
    l = int'(line);
    c = int'(col);
    if (l < 1 || l > num_lines || c < 1 || c > num_cols) return 1'b0;
    if (l == 1) return (c == 1 || c == 3 || c == 5 || c == 7);
    return 1'b1;
  endfunction

  // Only meaningful for positions that pass slot_valid.
  function automatic logic [SLOT_IDX_W-1:0] slot_index(input logic [LINE_W-1:0] line,
                                                       input logic [COL_W-1:0]  col,
                                                       input int num_cols = NUM_COLS_DEF);
    int idx;
    idx = (int'(line) - 1) * num_cols + (int'(col) - 1);
    return SLOT_IDX_W'(idx);
  endfunction

endpackage

// File: rtl/capacity_arbiter_if.sv
// capacity_arbiter_if: admin/customer request handshakes, busy, display read
// port and (with SOLDOUT_MAP_EN) the sold-out bitmap.
//   master: requester/display side; slave: the arbiter.
interface capacity_arbiter_if #(parameter int NUM_SLOTS = 48);
  import capacity_pkg::*;

  logic              adm_req;
  logic [LINE_W-1:0] adm_line;
  logic [COL_W-1:0]  adm_col;
  logic [CAP_W-1:0]  adm_delta;
  logic              adm_gnt;
  logic              adm_done;
  logic              adm_err;
  logic              cus_req;
  logic [LINE_W-1:0] cus_line;
  logic [COL_W-1:0]  cus_col;
  logic              cus_gnt;
  logic              cus_done;
  logic              cus_err;
  logic              busy;
  logic [LINE_W-1:0] rd_line;
  logic [COL_W-1:0]  rd_col;
  logic [CAP_W-1:0]  rd_capacity;
`ifdef SOLDOUT_MAP_EN
  logic [NUM_SLOTS-1:0] soldout_map;
`endif

  modport master (
    output adm_req, adm_line, adm_col, adm_delta,
    output cus_req, cus_line, cus_col,
    output rd_line, rd_col,
    input  adm_gnt, adm_done, adm_err,
    input  cus_gnt, cus_done, cus_err,
    input  busy, rd_capacity
`ifdef SOLDOUT_MAP_EN
    , input soldout_map
`endif
  );

  modport slave (
    input  adm_req, adm_line, adm_col, adm_delta,
    input  cus_req, cus_line, cus_col,
    input  rd_line, rd_col,
    output adm_gnt, adm_done, adm_err,
    output cus_gnt, cus_done, cus_err,
    output busy, rd_capacity
`ifdef SOLDOUT_MAP_EN
    , output soldout_map
`endif
  );

endinterface

// File: rtl/capacity_regfile.sv
// capacity_regfile: NUM_LINES x NUM_COLS capacity counters.
//   clk, reset (async, active-low: valid slots -> INIT_CAP, invalid -> 0)
//   wr_*  : single write port (ignored for invalid positions)
//   fsm_* : combinational read port for the arbiter
//   disp_*: combinational read port for the display; invalid position reads 0
module capacity_regfile
  import capacity_pkg::*;
#(
  parameter int NUM_LINES = 6,
  parameter int NUM_COLS  = 8,
  parameter int INIT_CAP  = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [LINE_W-1:0] wr_line,
  input  logic [COL_W-1:0]  wr_col,
  input  logic [CAP_W-1:0]  wr_data,
  input  logic [LINE_W-1:0] fsm_line,
  input  logic [COL_W-1:0]  fsm_col,
  output logic [CAP_W-1:0]  fsm_data,
  input  logic [LINE_W-1:0] disp_line,
  input  logic [COL_W-1:0]  disp_col,
  output logic [CAP_W-1:0]  disp_data
);

  localparam int NUM_SLOTS = NUM_LINES * NUM_COLS;

  logic [CAP_W-1:0] mem_q [NUM_SLOTS];
  logic [CAP_W-1:0] mem_d [NUM_SLOTS];

  function automatic logic [CAP_W-1:0] reset_val(input int i);
    return slot_valid(LINE_W'(i / NUM_COLS + 1), COL_W'(i % NUM_COLS + 1),
                      NUM_LINES, NUM_COLS) ? CAP_W'(INIT_CAP) : '0;
  endfunction

  always_comb begin
    mem_d = mem_q;
    if (wr_en && slot_valid(wr_line, wr_col, NUM_LINES, NUM_COLS))
      mem_d[slot_index(wr_line, wr_col, NUM_COLS)] = wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_SLOTS; i++) mem_q[i] <= reset_val(i);
    end else begin
      mem_q <= mem_d;
    end
  end

  assign fsm_data  = slot_valid(fsm_line, fsm_col, NUM_LINES, NUM_COLS)
                   ? mem_q[slot_index(fsm_line, fsm_col, NUM_COLS)] : '0;
  assign disp_data = slot_valid(disp_line, disp_col, NUM_LINES, NUM_COLS)
                   ? mem_q[slot_index(disp_line, disp_col, NUM_COLS)] : '0;

endmodule

// File: rtl/capacity_arbiter.sv
// capacity_arbiter: serialises admin restock (signed delta) and customer
// dispense (-1) onto the capacity register file, validating position/range.
//   clk, reset (async, active-low), bus (capacity_arbiter_if.slave).
// Optional SOLDOUT_MAP_EN adds the registered bus.soldout_map bitmap.
//
// state   | meaning
// IDLE    | waiting; grants a requester and latches its operands
// CHECK   | reads latched slot, computes new count and error flag
// COMMIT  | writes new count and pulses done, or pulses err
// RELEASE | waits for the winner to drop req
module capacity_arbiter
  import capacity_pkg::*;
#(
  parameter int NUM_LINES = 6,
  parameter int NUM_COLS  = 8,
  parameter int MAX_CAP   = 9,
  parameter int INIT_CAP  = 9
) (
  input logic clk,
  input logic reset,
  capacity_arbiter_if.slave bus
);

  state_e            state_q, state_d;
  req_id_e           ptr_q, ptr_d;
  req_id_e           win_q, win_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [CAP_W-1:0]  delta_q, delta_d;
  logic [CAP_W-1:0]  new_q, new_d;
  logic              err_q, err_d;

  logic              adm_gnt, cus_gnt;
  logic              wr_en;
  logic [CAP_W-1:0]  fsm_cap;
  logic [CAP_W:0]    sum;
  req_id_e           winner;

  capacity_regfile #(
    .NUM_LINES(NUM_LINES), .NUM_COLS(NUM_COLS), .INIT_CAP(INIT_CAP)
  ) u_regfile (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_line   (line_q),
    .wr_col    (col_q),
    .wr_data   (new_q),
    .fsm_line  (line_q),
    .fsm_col   (col_q),
    .fsm_data  (fsm_cap),
    .disp_line (bus.rd_line),
    .disp_col  (bus.rd_col),
    .disp_data (bus.rd_capacity)
  );

  // 6-bit two's-complement sum; range -16..24 cannot wrap.
  assign sum = {1'b0, fsm_cap} + {delta_q[CAP_W-1], delta_q};

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    win_d        = win_q;
    line_d       = line_q;
    col_d        = col_q;
    delta_d      = delta_q;
    new_d        = new_q;
    err_d        = err_q;
    adm_gnt      = 1'b0;
    cus_gnt      = 1'b0;
    wr_en        = 1'b0;
    bus.adm_done = 1'b0;
    bus.adm_err  = 1'b0;
    bus.cus_done = 1'b0;
    bus.cus_err  = 1'b0;
    winner       = bus.adm_req ? REQ_ADM : REQ_CUS;
    case (state_q)
      IDLE: begin
        if (bus.adm_req || bus.cus_req) begin
          if (bus.adm_req && bus.cus_req) begin
            winner = ptr_q;
            ptr_d  = (ptr_q == REQ_ADM) ? REQ_CUS : REQ_ADM;
          end
          win_d   = winner;
          state_d = CHECK;
          if (winner == REQ_ADM) begin
            line_d  = bus.adm_line;
            col_d   = bus.adm_col;
            delta_d = bus.adm_delta;
            adm_gnt = 1'b1;
          end else begin
            line_d  = bus.cus_line;
            col_d   = bus.cus_col;
            delta_d = '1;
            cus_gnt = 1'b1;
          end
        end
      end
      CHECK: begin
        new_d   = sum[CAP_W-1:0];
        err_d   = !slot_valid(line_q, col_q, NUM_LINES, NUM_COLS)
                  || sum[CAP_W]
                  || (sum[CAP_W-1:0] > CAP_W'(MAX_CAP));
        state_d = COMMIT;
      end
      COMMIT: begin
        wr_en        = !err_q;
        bus.adm_done = (win_q == REQ_ADM) && !err_q;
        bus.adm_err  = (win_q == REQ_ADM) &&  err_q;
        bus.cus_done = (win_q == REQ_CUS) && !err_q;
        bus.cus_err  = (win_q == REQ_CUS) &&  err_q;
        state_d      = RELEASE;
      end
      RELEASE: begin
        if (!((win_q == REQ_ADM) ? bus.adm_req : bus.cus_req)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= REQ_ADM;
      win_q   <= REQ_ADM;
      line_q  <= '0;
      col_q   <= '0;
      delta_q <= '0;
      new_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      line_q  <= line_d;
      col_q   <= col_d;
      delta_q <= delta_d;
      new_q   <= new_d;
      err_q   <= err_d;
    end
  end

  // Grants are combinational from IDLE; mask them while reset is held so a
  // request present during reset does not produce a pulse.
  assign bus.adm_gnt = adm_gnt && reset;
  assign bus.cus_gnt = cus_gnt && reset;
  assign bus.busy    = (state_q != IDLE);

`ifdef SOLDOUT_MAP_EN
  localparam int NUM_SLOTS = NUM_LINES * NUM_COLS;
  logic [NUM_SLOTS-1:0] soldout_q, soldout_d;

  // Writes only ever target valid slots, so invalid bits never leave 0.
  always_comb begin
    soldout_d = soldout_q;
    if (wr_en) soldout_d[slot_index(line_q, col_q, NUM_COLS)] = (new_q == '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) soldout_q <= '0;
    else        soldout_q <= soldout_d;
  end

  assign bus.soldout_map = soldout_q;
`endif

endmodule

// File: doc/capacity_arbiter.md
Name: capacity_arbiter

Overview:
- Owns the product-capacity register file: 6 lines × 8 columns, 5-bit counts. Line 1 exposes only columns 1, 3, 5 and 7.
- Serialises two requesters onto that shared storage:
  - the admin restock path, which commits a signed delta;
  - the customer dispense path, which decrements by 1.
- Validates position and range, then writes back.
- Provides the capacity_lineXY view consumed by the admin and display logic.

Parameters:
- NUM_LINES, 6, number of product lines, addressed 1..NUM_LINES.
- NUM_COLS, 8, columns per line, addressed 1..NUM_COLS.
- MAX_CAP, 9, maximum items per slot.
- INIT_CAP, 9, value loaded into every valid slot on reset.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- adm_req  in  1  admin commit request, level; held until adm_done or adm_err.
- adm_line  in  3  admin target line, 1-based.
- adm_col  in  4  admin target column, 1-based.
- adm_delta  in  5  signed capacity change, -16..+15.
- adm_gnt  out  1  one-cycle pulse: admin request accepted.
- adm_done  out  1  one-cycle pulse: admin write committed.
- adm_err  out  1  one-cycle pulse: admin request rejected (bad position or out of range).
- cus_req  in  1  customer dispense request, level.
- cus_line  in  3  customer target line.
- cus_col  in  4  customer target column.
- cus_gnt  out  1  one-cycle pulse: customer request accepted.
- cus_done  out  1  one-cycle pulse: item dispensed, count decremented.
- cus_err  out  1  one-cycle pulse: bad position or slot empty.
- busy  out  1  high in every state except IDLE.
- rd_line  in  3  display read line.
- rd_col  in  4  display read column.
- rd_capacity  out  5  combinational capacity at rd_line/rd_col; 0 for an invalid position.

Behaviour:
Reset (reset low, asynchronous):
- State goes to IDLE.
- All pulse outputs and busy go to 0.
- Every valid slot is loaded with INIT_CAP; invalid slots (line 1, even columns) are held at 0.
- Round-robin pointer is set to favour admin.
- An operation in flight is abandoned with no write and no done/err pulse.

Valid position:
- line 1: column ∈ {1, 3, 5, 7};
- lines 2..NUM_LINES: column 1..NUM_COLS;
- anything else is invalid.

FSM, with cycle 0 defined as the first IDLE cycle in which a request is high:
- IDLE:
  - On any request, select the winner.
  - Latch its line, column and operation (delta, or -1 for customer).
  - Pulse the winner's gnt in the same cycle and go to CHECK.
- CHECK (cycle 1):
  - Read the latched slot.
  - Compute new = cap + delta in 6-bit signed arithmetic.
  - Set err_flag if the position is invalid, new < 0, or new > MAX_CAP.
  - For a customer request, cap = 0 therefore sets err_flag.
  - Go to COMMIT.
- COMMIT (cycle 2):
  - If err_flag is clear: write new and pulse done.
  - If err_flag is set: no write; pulse err.
  - Go to RELEASE.
- RELEASE:
  - Wait until the winner's req is low, then return to IDLE.
  - Four-phase handshake: a held req is never re-served.

Arbitration:
- Single requester: it wins.
- Both requesting in IDLE: the pointer side wins; the pointer then flips to the other side.
- Pointer updates only on contention.
- The loser keeps req high and is granted at the next IDLE, at the earliest 1 cycle after the winner drops req.

Other rules:
- Operands are sampled only in the IDLE grant cycle; later changes are ignored.
- If req drops before done/err, the operation still completes and the pulse still fires.
- rd_capacity reflects a COMMIT write from the following cycle.
- Zero delta is a legal admin commit: done pulses, value unchanged.

Optional Feature:
Macro SOLDOUT_MAP_EN.
- Defined:
  - Adds output soldout_map, width NUM_LINES*NUM_COLS, bit index (line-1)*NUM_COLS+(col-1).
  - Registered: a bit is 1 when its valid slot holds 0.
  - Updated in the same edge as the COMMIT write.
  - Reset value is all zeros.
  - Invalid-slot bits are tied to 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package capacity_pkg holds:
  - LINE_W = 3, COL_W = 4, CAP_W = 5;
  - the state enum {IDLE, CHECK, COMMIT, RELEASE};
  - a requester-id enum {REQ_ADM, REQ_CUS};
  - a function slot_valid(line, col);
  - a function slot_index(line, col).
- One sub-module, capacity_regfile:
  - storage with asynchronous active-low reset to INIT_CAP;
  - one write port;
  - two combinational read ports (FSM and display).
- The arbiter FSM stays in capacity_arbiter.

Test Plan:
- Reset release, then rd at (2,3) → rd_capacity = 9. rd at (1,2) → 0.
- cus_req at (3,5) after reset → cus_gnt at cycle 0, cus_done at cycle 2, rd_capacity(3,5) = 8.
- adm_req at (4,1) with delta -9 → done, cap = 0. Then cus_req at (4,1) → cus_err, cap stays 0; with SOLDOUT_MAP_EN, soldout_map[24] = 1.
- adm delta +1 on a full slot (2,2) → adm_err, cap stays 9. adm at (1,4) → adm_err, no write. adm at (7,1) → adm_err.
- adm_req and cus_req asserted in the same cycle, twice, with req dropped after each response:
  - first grant to admin, second to customer;
  - the loser is served after the winner releases;
  - counts reflect both operations.
- Assert reset low during CHECK of a customer request → no cus_done/cus_err, busy = 0, slot back at INIT_CAP = 9.
